// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Brief    : PS/2 device-to-host receiver with glitch filters, frame checks,
//            stall timeout and a valid/ready output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_AW        = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               rd_ready,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               parity_err,
    output logic               frame_err,
    output logic               timeout_err,
    output logic               overflow
);

    localparam int                c_depth_i = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]  c_depth   = (FIFO_AW + 1)'(c_depth_i);
    localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        c_flt_top = 4'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Index 0 carries the PS/2 clock line, index 1 the data line.
    logic [1:0] w_pin;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_filt;
    logic [3:0] r_fcnt [2];

    assign w_pin = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filter
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sync1[gi] <= 1'b1;
                    r_sync2[gi] <= 1'b1;
                    r_filt[gi]  <= 1'b1;
                    r_fcnt[gi]  <= 4'd0;
                end else begin
                    r_sync1[gi] <= w_pin[gi];
                    r_sync2[gi] <= r_sync1[gi];
                    // Change only after FILTER_LEN consecutive disagreeing samples.
                    if (r_sync2[gi] == r_filt[gi]) begin
                        r_fcnt[gi] <= 4'd0;
                    end else if (r_fcnt[gi] == c_flt_top) begin
                        r_filt[gi] <= r_sync2[gi];
                        r_fcnt[gi] <= 4'd0;
                    end else begin
                        r_fcnt[gi] <= r_fcnt[gi] + 4'd1;
                    end
                end
            end
        end
    endgenerate

    logic r_clk_prev;
    logic w_fall;
    logic w_bit;

    assign w_fall = r_clk_prev & ~r_filt[0];
    assign w_bit  = r_filt[1];

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_par;
    logic [c_to_w-1:0]   r_to_cnt;
    logic                w_timeout;
    logic                r_push;
    logic                r_perr;
    logic                r_ferr;
    logic                r_terr;

    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == c_to_last);

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_bit) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_clk_prev <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_prev <= r_filt[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
            r_push    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_terr    <= 1'b0;
        end else begin
            r_push <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_terr <= w_timeout;

            if (r_state == S_IDLE || w_fall || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_fall && !w_timeout) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_bit) r_bit_cnt <= 3'd0;
                    end
                    S_DATA: begin
                        r_shift[r_bit_cnt] <= w_bit;
                        r_bit_cnt          <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: begin
                        r_par <= w_bit;
                    end
                    S_STOP: begin
                        // Stop-bit error outranks parity; odd parity expected.
                        if (!w_bit) begin
                            r_ferr <= 1'b1;
                        end else if (^{r_shift, r_par} == 1'b0) begin
                            r_perr <= 1'b1;
                        end else begin
                            r_push <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign parity_err  = r_perr;
    assign frame_err   = r_ferr;
    assign timeout_err = r_terr;

    logic [7:0]         r_mem [c_depth_i];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic [7:0]         r_hold;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;

    assign rd_valid   = (r_level != '0);
    assign w_full     = (r_level == c_depth);
    assign w_pop      = rd_valid & rd_ready;
    assign w_wr       = r_push & (~w_full | w_pop);
    assign overflow   = r_push & w_full & ~w_pop;
    assign fifo_level = r_level;
    assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : r_hold;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_hold   <= 8'd0;
        end else begin
            // Remember the visible head so rd_data is stable once drained.
            if (rd_valid) r_hold <= r_mem[r_rd_ptr];
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Brief    : Directed self-checking bench for ps2_rx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

    localparam int H  = 20;   // clk cycles per PS/2 clock half period
    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] fifo_level;
    logic       parity_err, frame_err, timeout_err, overflow;

    int total = 0;
    int bad   = 0;
    int n_perr = 0, n_ferr = 0, n_terr = 0, n_ovf = 0;

    ps2_rx_fifo #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .FIFO_AW(3)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_level(fifo_level), .parity_err(parity_err), .frame_err(frame_err),
        .timeout_err(timeout_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Each pulse cycle counts once, so a stretched pulse shows as an extra count.
    always @(negedge clk) begin
        if (parity_err)  n_perr++;
        if (frame_err)   n_ferr++;
        if (timeout_err) n_terr++;
        if (overflow)    n_ovf++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input int g);
        ps2_data = b;
        wait_cyc(H / 2);
        if (g > 0) begin
            ps2_clk = 1'b0;
            wait_cyc(g);
            ps2_clk = 1'b1;
        end
        wait_cyc(H / 2 - g);
        ps2_clk = 1'b0;
        wait_cyc(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int g);
        ps2_bit(1'b0, g);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], g);
        ps2_bit(p, g);
        ps2_bit(s, g);
        ps2_data = 1'b1;
        wait_cyc(10);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        wait_cyc(1);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        wait_cyc(3);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rd_data); end
        rst = 1'b1;
        wait_cyc(10);
        total++; if ((n_perr + n_ferr + n_terr + n_ovf) !== 0) begin bad++; $display("FAIL reset_pulses got=%0d exp=0", n_perr + n_ferr + n_terr + n_ovf); end
    endtask

    task automatic test_single();
        int e0;
        e0 = n_perr + n_ferr + n_terr + n_ovf;
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rd_valid); end
        total++; if (rd_data !== 8'h1C) begin bad++; $display("FAIL single_data got=%h exp=1c", rd_data); end
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
        total++; if ((n_perr + n_ferr + n_terr + n_ovf) !== e0) begin bad++; $display("FAIL single_errs got=%0d exp=%0d", n_perr + n_ferr + n_terr + n_ovf, e0); end
        pop_one();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 8'h1C) begin bad++; $display("FAIL single_hold got=%h exp=1c", rd_data); end
        pop_one();
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL single_empty_pop got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_errors();
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h00, 1'b0, 1'b1, 0);
        total++; if (n_perr - p0 !== 1) begin bad++; $display("FAIL parity_pulse got=%0d exp=1", n_perr - p0); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL parity_level got=%0d exp=0", fifo_level); end
        p0 = n_perr;
        send_frame(8'h00, 1'b1, 1'b0, 0);
        wait_cyc(H);
        total++; if (n_ferr - f0 !== 1) begin bad++; $display("FAIL frame_pulse got=%0d exp=1", n_ferr - f0); end
        total++; if (n_perr - p0 !== 0) begin bad++; $display("FAIL frame_noparity got=%0d exp=0", n_perr - p0); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL frame_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_timeout();
        int t0;
        t0 = n_terr;
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
        wait_cyc(TO - 40);
        total++; if (n_terr - t0 !== 0) begin bad++; $display("FAIL timeout_early got=%0d exp=0", n_terr - t0); end
        wait_cyc(80);
        total++; if (n_terr - t0 !== 1) begin bad++; $display("FAIL timeout_pulse got=%0d exp=1", n_terr - t0); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL timeout_valid got=%b exp=0", rd_valid); end
        send_frame(8'hF0, 1'b1, 1'b1, 0);
        total++; if (rd_data !== 8'hF0) begin bad++; $display("FAIL timeout_next_data got=%h exp=f0", rd_data); end
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL timeout_next_level got=%0d exp=1", fifo_level); end
        pop_one();
    endtask

    task automatic test_glitch();
        int e0;
        e0 = n_perr + n_ferr + n_terr + n_ovf;
        ps2_data = 1'b0;
        wait_cyc(10);
        for (int g = 1; g <= 3; g++) begin
            ps2_clk = 1'b0;
            wait_cyc(g);
            ps2_clk = 1'b1;
            wait_cyc(10);
        end
        ps2_data = 1'b1;
        wait_cyc(20);
        send_frame(8'hAA, 1'b1, 1'b1, 3);
        total++; if (rd_data !== 8'hAA) begin bad++; $display("FAIL glitch_data got=%h exp=aa", rd_data); end
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL glitch_level got=%0d exp=1", fifo_level); end
        wait_cyc(TO + 20);
        total++; if ((n_perr + n_ferr + n_terr + n_ovf) !== e0) begin bad++; $display("FAIL glitch_errs got=%0d exp=%0d", n_perr + n_ferr + n_terr + n_ovf, e0); end
        pop_one();
    endtask

    task automatic test_overflow();
        int o0;
        o0 = n_ovf;
        for (int i = 1; i <= 8; i++) send_frame(8'(i), ~^(8'(i)), 1'b1, 0);
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovf_fill_level got=%0d exp=8", fifo_level); end
        total++; if (n_ovf - o0 !== 0) begin bad++; $display("FAIL ovf_none_yet got=%0d exp=0", n_ovf - o0); end
        send_frame(8'h09, 1'b1, 1'b1, 0);
        total++; if (n_ovf - o0 !== 1) begin bad++; $display("FAIL ovf_pulse got=%0d exp=1", n_ovf - o0); end
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
        for (int i = 1; i <= 8; i++) begin
            total++; if (rd_data !== 8'(i)) begin bad++; $display("FAIL ovf_drain got=%h exp=%h", rd_data, 8'(i)); end
            pop_one();
        end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", rd_valid); end
    endtask

    task automatic test_full_push_pop();
        int o0;
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), ~^(8'h10 + 8'(i)), 1'b1, 0);
        o0 = n_ovf;
        total++; if (rd_data !== 8'h10) begin bad++; $display("FAIL pp_head got=%h exp=10", rd_data); end
        // 0x18: ones=2, odd parity bit 1; hold rd_ready exactly in the push cycle.
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) ps2_bit(((8'h18 >> i) & 8'h01) != 0, 0);
        ps2_bit(1'b1, 0);
        ps2_data = 1'b1;
        wait_cyc(H / 2);
        ps2_clk = 1'b0;
        wait_cyc(7);
        rd_ready = 1'b1;
        wait_cyc(1);
        rd_ready = 1'b0;
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL pp_level got=%0d exp=8", fifo_level); end
        wait_cyc(H);
        ps2_clk = 1'b1;
        wait_cyc(10);
        total++; if (n_ovf - o0 !== 0) begin bad++; $display("FAIL pp_overflow got=%0d exp=0", n_ovf - o0); end
        for (int i = 1; i <= 8; i++) begin
            total++; if (rd_data !== 8'h10 + 8'(i)) begin bad++; $display("FAIL pp_drain got=%h exp=%h", rd_data, 8'h10 + 8'(i)); end
            pop_one();
        end
    endtask

    task automatic test_reset_midframe();
        int e0;
        e0 = n_perr + n_ferr + n_terr + n_ovf;
        send_frame(8'h55, 1'b1, 1'b1, 0);
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL rst_pre_level got=%0d exp=1", fifo_level); end
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b0, 0);
        ps2_data = 1'b1;
        #2 rst = 1'b0;
        #2;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", rd_valid); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL rst_mid_level got=%0d exp=0", fifo_level); end
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(TO + 20);
        total++; if ((n_perr + n_ferr + n_terr + n_ovf) !== e0) begin bad++; $display("FAIL rst_mid_pulses got=%0d exp=%0d", n_perr + n_ferr + n_terr + n_ovf, e0); end
        send_frame(8'h3C, 1'b1, 1'b1, 0);
        total++; if (rd_data !== 8'h3C) begin bad++; $display("FAIL rst_after_data got=%h exp=3c", rd_data); end
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL rst_after_level got=%0d exp=1", fifo_level); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_errors();
        test_timeout();
        test_glitch();
        test_overflow();
        test_full_push_pop();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
